// File: rtl/pwm_sched_pkg.sv
// Shared constants and state encoding for the PWM frame scheduler.
// Module/phase counts and sine-index offsets are fixed package defaults.
package pwm_sched_pkg;

    localparam int DEF_NUM_MODULES = 9;

    localparam int DEF_NUM_PHASES = 3;

    localparam logic [15:0] DEF_MODULE_OFFSET = 16'd28;

    localparam logic [15:0] DEF_PHASE_OFFSET = 16'd85;

    localparam int DEF_SHOOT_CYCLES   = 48;
    localparam int DEF_TX_TIMEOUT     = 4800;
    localparam int TX_BLANK_CYCLES    = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_DISPATCH,
        ST_WAIT_TX,
        ST_SHOOT
    } sched_state_t;

    // Counter width for an index range of n values, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_frame_scheduler_sin_index_gen.sv
// Module/phase index counters and the registered modulo-2^16 sine address.
// The address is kept incrementally so no multiplier is needed.
module sin_index_gen
    import pwm_sched_pkg::*;
#(
    parameter int          NUM_MODULES   = DEF_NUM_MODULES,
    parameter int          NUM_PHASES    = DEF_NUM_PHASES,
    parameter logic [15:0] MODULE_OFFSET = DEF_MODULE_OFFSET,
    parameter logic [15:0] PHASE_OFFSET  = DEF_PHASE_OFFSET,
    localparam int         MW            = idx_width(NUM_MODULES),
    localparam int         PW            = idx_width(NUM_PHASES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [15:0]   base_index,
    input  logic          next_module,
    input  logic          next_phase,
    output logic [15:0]   addr,
    output logic [MW-1:0] module_idx,
    output logic          last_module,
    output logic          last_phase
);

    logic [15:0]   phase_base;
    logic [PW-1:0] phase_idx;

    // phase_base is the latched base plus j*PHASE_OFFSET; addr adds i*MODULE_OFFSET on top.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr       <= '0;
            phase_base <= '0;
            module_idx <= '0;
            phase_idx  <= '0;
        end else if (start) begin
            addr       <= base_index;
            phase_base <= base_index;
            module_idx <= '0;
            phase_idx  <= '0;
        end else if (next_phase) begin
            addr       <= phase_base + PHASE_OFFSET;
            phase_base <= phase_base + PHASE_OFFSET;
            module_idx <= '0;
            phase_idx  <= phase_idx + 1'b1;
        end else if (next_module) begin
            addr       <= addr + MODULE_OFFSET;
            module_idx <= module_idx + 1'b1;
        end
    end

    assign last_module = (module_idx == MW'(NUM_MODULES - 1));
    assign last_phase  = (phase_idx == PW'(NUM_PHASES - 1));

endmodule

// File: rtl/pwm_frame_scheduler.sv
// Frame sequencer: loads one byte per module from the sine RAM, launches all UARTs
// together once per phase, then fires the shoot pulse; aborts if a UART never goes idle.
module pwm_frame_scheduler
    import pwm_sched_pkg::*;
#(
    parameter int          NUM_MODULES   = DEF_NUM_MODULES,
    parameter int          NUM_PHASES    = DEF_NUM_PHASES,
    parameter logic [15:0] MODULE_OFFSET = DEF_MODULE_OFFSET,
    parameter logic [15:0] PHASE_OFFSET  = DEF_PHASE_OFFSET,
    parameter int          SHOOT_CYCLES  = DEF_SHOOT_CYCLES,
    parameter int          TX_TIMEOUT    = DEF_TX_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_start,
    input  logic [15:0]              base_index,
    output logic [15:0]              sin_addr,
    input  logic [7:0]               sin_data,
    output logic [8*NUM_MODULES-1:0] data_to_tx,
    output logic [NUM_MODULES-1:0]   start_tx,
    input  logic [NUM_MODULES-1:0]   tx_busy,
    output logic                     shoot,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     tx_timeout
);

    localparam int MW = idx_width(NUM_MODULES);
    localparam int TW = $clog2(TX_TIMEOUT + 2);
    localparam int SW = idx_width(SHOOT_CYCLES);

    sched_state_t  state;
    sched_state_t  state_next;

    logic [TW-1:0] wait_cnt;
    logic [SW-1:0] shoot_cnt;

    logic          gen_start;
    logic          gen_next_module;
    logic          gen_next_phase;
    logic          load_en;
    logic [MW-1:0] module_idx;
    logic          last_module;
    logic          last_phase;

    logic          tx_idle;
    logic          tx_done;
    logic          timed_out;
    logic          shoot_last;

    logic [NUM_MODULES-1:0][7:0] tx_bytes;

    sin_index_gen #(
        .NUM_MODULES   (NUM_MODULES),
        .NUM_PHASES    (NUM_PHASES),
        .MODULE_OFFSET (MODULE_OFFSET),
        .PHASE_OFFSET  (PHASE_OFFSET)
    ) u_index_gen (
        .clk         (clk),
        .reset       (reset),
        .start       (gen_start),
        .base_index  (base_index),
        .next_module (gen_next_module),
        .next_phase  (gen_next_phase),
        .addr        (sin_addr),
        .module_idx  (module_idx),
        .last_module (last_module),
        .last_phase  (last_phase)
    );

    // Busy is ignored during the blanking window; success beats a coincident timeout.
    assign tx_idle    = (tx_busy == '0);
    assign tx_done    = (state == ST_WAIT_TX) && (wait_cnt >= TW'(TX_BLANK_CYCLES)) && tx_idle;
    assign timed_out  = (state == ST_WAIT_TX) && (wait_cnt == TW'(TX_TIMEOUT)) && !tx_done;
    assign shoot_last = (shoot_cnt == SW'(SHOOT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (frame_start) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                state_next = last_module ? ST_DISPATCH : ST_FETCH;
            end
            ST_DISPATCH: begin
                if (tx_idle) begin
                    state_next = ST_WAIT_TX;
                end
            end
            ST_WAIT_TX: begin
                if (tx_done) begin
                    state_next = last_phase ? ST_SHOOT : ST_FETCH;
                end else if (timed_out) begin
                    state_next = ST_IDLE;
                end
            end
            ST_SHOOT: begin
                if (shoot_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // start_tx covers exactly the first WAIT_TX cycle, i.e. the cycle after DISPATCH saw idle UARTs.
    always_comb begin
        gen_start       = 1'b0;
        gen_next_module = 1'b0;
        gen_next_phase  = 1'b0;
        load_en         = 1'b0;
        start_tx        = '0;
        shoot           = 1'b0;
        frame_done      = 1'b0;
        tx_timeout      = 1'b0;
        busy            = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                gen_start = frame_start;
            end
            ST_LOAD: begin
                load_en         = 1'b1;
                gen_next_module = !last_module;
            end
            ST_WAIT_TX: begin
                start_tx       = (wait_cnt == '0) ? '1 : '0;
                gen_next_phase = tx_done && !last_phase;
                tx_timeout     = timed_out;
            end
            ST_SHOOT: begin
                shoot      = 1'b1;
                frame_done = shoot_last;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= '0;
            shoot_cnt <= '0;
        end else begin
            wait_cnt  <= (state == ST_WAIT_TX) ? wait_cnt + 1'b1 : '0;
            shoot_cnt <= (state == ST_SHOOT) ? shoot_cnt + 1'b1 : '0;
        end
    end

    // Bytes persist between frames so the last table stays visible to the UARTs.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_bytes <= '0;
        end else if (load_en) begin
            tx_bytes[module_idx] <= sin_data;
        end
    end

    assign data_to_tx = tx_bytes;

endmodule

// File: tb/tb_pwm_frame_scheduler.sv
// Self-checking bench for pwm_frame_scheduler: RAM and UART models, a scoreboard of
// expected per-phase byte tables, a vector table of frames and hand-built corner sequences.
module tb_pwm_frame_scheduler;
    import pwm_sched_pkg::*;

    localparam int NM    = DEF_NUM_MODULES;
    localparam int NP    = DEF_NUM_PHASES;
    localparam int DW    = 8 * NM;
    localparam int LAT0  = 2 * NM + 2;
    localparam int SHOOT = DEF_SHOOT_CYCLES;
    localparam int TOUT  = DEF_TX_TIMEOUT;

    typedef struct {
        logic [15:0] base;
        bit          xr;
        int          blen;
        int          exp_strobes;
        int          exp_done;
        int          exp_shoot;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_start;
    logic [15:0]   base_index;
    logic [15:0]   sin_addr;
    logic [7:0]    sin_data = 8'h00;
    logic [DW-1:0] data_to_tx;
    logic [NM-1:0] start_tx;
    logic [NM-1:0] tx_busy;
    logic          shoot;
    logic          busy;
    logic          frame_done;
    logic          tx_timeout;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;

    int            busy_len = 100;
    bit            ram_xor = 1'b0;
    bit            stuck_mode = 1'b0;
    bit            force0 = 1'b0;
    logic          stuck_latched;
    int            uart_cnt [NM];

    int            strobe_count = 0;
    int            done_count = 0;
    int            timeout_count = 0;
    int            shoot_total = 0;
    int            shoot_run = 0;
    int            last_strobe_cyc = 0;

    logic [DW-1:0] exp_q [$];

    pwm_frame_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .base_index (base_index),
        .sin_addr   (sin_addr),
        .sin_data   (sin_data),
        .data_to_tx (data_to_tx),
        .start_tx   (start_tx),
        .tx_busy    (tx_busy),
        .shoot      (shoot),
        .busy       (busy),
        .frame_done (frame_done),
        .tx_timeout (tx_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sine RAM stand-in: one cycle of read latency, contents derived from the address.
    always @(posedge clk) begin
        sin_data <= ram_xor ? (sin_addr[7:0] ^ sin_addr[15:8]) : sin_addr[7:0];
    end

    // UART models: busy for busy_len cycles after each start strobe; module 4 can latch stuck.
    always @(posedge clk) begin
        if (reset) begin
            for (int m = 0; m < NM; m++) uart_cnt[m] <= 0;
            stuck_latched <= 1'b0;
        end else begin
            for (int m = 0; m < NM; m++) begin
                if (start_tx[m]) uart_cnt[m] <= busy_len;
                else if (uart_cnt[m] > 0) uart_cnt[m] <= uart_cnt[m] - 1;
            end
            if (!stuck_mode) stuck_latched <= 1'b0;
            else if (start_tx[4]) stuck_latched <= 1'b1;
        end
    end

    always_comb begin
        tx_busy = '0;
        for (int m = 0; m < NM; m++) tx_busy[m] = (uart_cnt[m] != 0);
        tx_busy[4] = tx_busy[4] | stuck_latched;
        tx_busy[0] = tx_busy[0] | force0;
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] expBytes(input logic [15:0] base, input int j, input bit xr);
        logic [DW-1:0] r;
        logic [15:0]   a;
        r = '0;
        for (int i = 0; i < NM; i++) begin
            a = base + 16'(i) * DEF_MODULE_OFFSET + 16'(j) * DEF_PHASE_OFFSET;
            r[8*i +: 8] = xr ? (a[7:0] ^ a[15:8]) : a[7:0];
        end
        return r;
    endfunction

    // Monitor: scoreboard pops on every strobe, plus shoot width and timeout latency.
    always @(negedge clk) begin
        if (!reset) begin
            if (start_tx != '0) begin
                strobe_count++;
                last_strobe_cyc = cyc;
                checkOutput("start_tx_all_ones", DW'(start_tx), DW'({NM{1'b1}}));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_strobe: got strobe at cycle %0d, expected none", cyc);
                end else begin
                    checkOutput("tx_bytes", data_to_tx, exp_q.pop_front());
                end
            end
            if (shoot) begin
                shoot_run++;
                shoot_total++;
            end else begin
                shoot_run = 0;
            end
            if (frame_done) begin
                done_count++;
                checkOutput("shoot_width_at_done", DW'(shoot_run), DW'(SHOOT));
            end
            if (tx_timeout) begin
                timeout_count++;
                checkOutput("timeout_latency", DW'(cyc - last_strobe_cyc), DW'(TOUT));
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] base, input bit xr, input int blen, output int f_cyc);
        busy_len = blen;
        ram_xor  = xr;
        for (int j = 0; j < NP; j++) exp_q.push_back(expBytes(base, j, xr));
        @(posedge clk); #1;
        base_index  = base;
        frame_start = 1'b1;
        f_cyc       = cyc;
        @(negedge clk);
        checkOutput("busy_before_accept", DW'(busy), DW'(0));
        @(posedge clk); #1;
        frame_start = 1'b0;
        base_index  = ~base;
        @(negedge clk);
        checkOutput("busy_after_accept", DW'(busy), DW'(1));
    endtask

    task automatic waitFirstStrobe(input int f_cyc, input int lat, output int e_cyc);
        int n;
        n = 0;
        while (start_tx == '0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        e_cyc = cyc;
        if (start_tx == '0) begin
            checks++;
            errors++;
            $display("[TB] FAIL first_strobe: got no strobe within 1000 cycles, expected one");
        end else begin
            checkOutput("first_strobe_latency", DW'(cyc - f_cyc), DW'(lat));
        end
    endtask

    task automatic waitFrameEnd(input int limit);
        int n;
        n = 0;
        while (!(frame_done || tx_timeout) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!(frame_done || tx_timeout)) begin
            checks++;
            errors++;
            $display("[TB] FAIL frame_end: got no frame_done/tx_timeout within %0d cycles, expected one", limit);
        end else begin
            @(negedge clk);
            checkOutput("busy_after_end", DW'(busy), DW'(0));
        end
    endtask

    initial begin
        vec_t vecs [4];
        int   f, e, s0, d0, t0, sh0;

        vecs[0] = '{16'h0000, 1'b0, 100, NP, 1, SHOOT};
        vecs[1] = '{16'hFFF0, 1'b1, 100, NP, 1, SHOOT};
        vecs[2] = '{16'h1234, 1'b1,  20, NP, 1, SHOOT};
        vecs[3] = '{16'hFF80, 1'b1,   5, NP, 1, SHOOT};

        reset       = 1'b1;
        frame_start = 1'b0;
        base_index  = 16'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_sin_addr",   DW'(sin_addr),   DW'(0));
        checkOutput("rst_data_to_tx", data_to_tx,      DW'(0));
        checkOutput("rst_start_tx",   DW'(start_tx),   DW'(0));
        checkOutput("rst_shoot",      DW'(shoot),      DW'(0));
        checkOutput("rst_busy",       DW'(busy),       DW'(0));
        checkOutput("rst_frame_done", DW'(frame_done), DW'(0));
        checkOutput("rst_tx_timeout", DW'(tx_timeout), DW'(0));

        for (int v = 0; v < 4; v++) begin
            s0 = strobe_count; d0 = done_count; t0 = timeout_count; sh0 = shoot_total;
            $display("[TB] vector %0d base=%04h busy_len=%0d", v, vecs[v].base, vecs[v].blen);
            applyStimulus(vecs[v].base, vecs[v].xr, vecs[v].blen, f);
            waitFirstStrobe(f, LAT0, e);
            waitFrameEnd(4000);
            checkOutput("vec_strobes",  DW'(strobe_count - s0),  DW'(vecs[v].exp_strobes));
            checkOutput("vec_done",     DW'(done_count - d0),    DW'(vecs[v].exp_done));
            checkOutput("vec_timeouts", DW'(timeout_count - t0), DW'(0));
            checkOutput("vec_shoot",    DW'(shoot_total - sh0),  DW'(vecs[v].exp_shoot));
            checkOutput("vec_queue",    DW'(exp_q.size()),       DW'(0));
            repeat (5) @(negedge clk);
        end

        $display("[TB] busy before dispatch");
        s0 = strobe_count; d0 = done_count;
        force0 = 1'b1;
        applyStimulus(16'h0420, 1'b0, 30, f);
        do begin @(posedge clk); #1; end while (cyc < f + 2 * NM + 1 + 50);
        force0 = 1'b0;
        checkOutput("no_early_start", DW'(strobe_count - s0), DW'(0));
        waitFirstStrobe(f, LAT0 + 50, e);
        waitFrameEnd(4000);
        checkOutput("bbd_strobes", DW'(strobe_count - s0), DW'(NP));
        checkOutput("bbd_done",    DW'(done_count - d0),   DW'(1));

        $display("[TB] request while busy");
        s0 = strobe_count; d0 = done_count;
        applyStimulus(16'h0300, 1'b0, 100, f);
        repeat (30) @(posedge clk);
        #1 frame_start = 1'b1; base_index = 16'h5555;
        @(posedge clk); #1 frame_start = 1'b0;
        begin
            int n;
            n = 0;
            while (!shoot && n < 2000) begin @(negedge clk); n++; end
        end
        checkOutput("rwb_shoot_reached", DW'(shoot), DW'(1));
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
        waitFrameEnd(2000);
        repeat (300) @(negedge clk);
        checkOutput("rwb_strobes", DW'(strobe_count - s0), DW'(NP));
        checkOutput("rwb_done",    DW'(done_count - d0),   DW'(1));
        checkOutput("rwb_idle",    DW'(busy),              DW'(0));

        $display("[TB] stuck UART");
        s0 = strobe_count; d0 = done_count; t0 = timeout_count; sh0 = shoot_total;
        stuck_mode = 1'b1;
        applyStimulus(16'h0777, 1'b0, 100, f);
        waitFirstStrobe(f, LAT0, e);
        waitFrameEnd(6000);
        checkOutput("stuck_timeouts", DW'(timeout_count - t0), DW'(1));
        checkOutput("stuck_done",     DW'(done_count - d0),    DW'(0));
        checkOutput("stuck_shoot",    DW'(shoot_total - sh0),  DW'(0));
        checkOutput("stuck_strobes",  DW'(strobe_count - s0),  DW'(1));
        checkOutput("stuck_leftover", DW'(exp_q.size()),       DW'(NP - 1));
        exp_q.delete();
        stuck_mode = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] reset mid-frame");
        s0 = strobe_count; d0 = done_count; sh0 = shoot_total;
        applyStimulus(16'h0101, 1'b0, 100, f);
        waitFirstStrobe(f, LAT0, e);
        do begin @(posedge clk); #1; end while (cyc < e + 103);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_phase1_addr", DW'(sin_addr), DW'(16'h0101 + DEF_PHASE_OFFSET));
        @(posedge clk); #1 reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checkOutput("mrst_sin_addr",   DW'(sin_addr),   DW'(0));
        checkOutput("mrst_data_to_tx", data_to_tx,      DW'(0));
        checkOutput("mrst_start_tx",   DW'(start_tx),   DW'(0));
        checkOutput("mrst_shoot",      DW'(shoot),      DW'(0));
        checkOutput("mrst_busy",       DW'(busy),       DW'(0));
        checkOutput("mrst_frame_done", DW'(frame_done), DW'(0));
        checkOutput("mrst_tx_timeout", DW'(tx_timeout), DW'(0));
        repeat (300) @(negedge clk);
        checkOutput("mrst_no_shoot",   DW'(shoot_total - sh0), DW'(0));
        checkOutput("mrst_no_done",    DW'(done_count - d0),   DW'(0));
        checkOutput("mrst_strobes",    DW'(strobe_count - s0), DW'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_frame_scheduler.md
# pwm_frame_scheduler

Sequences one switching frame for all power modules. Each frame reads per-module, per-phase duty codes from the sine RAM, loads them into the per-module `uart_tx` instances, and launches all nine transmitters together, one phase at a time. When the last phase has been transmitted, it issues the `shoot` pulse. It replaces the ad-hoc NORMAL_MODE loop in the top level and sits between the top-level mode FSM, the `RAM` sine table and the `uart_tx` array.

## Interface
Parameters:
- `NUM_MODULES`, 9, number of UART-attached power modules
- `NUM_PHASES`, 3, phases sent per frame
- `MODULE_OFFSET`, `` `MODULE_OFFSET ``, sine-index step between modules
- `PHASE_OFFSET`, `` `PHASE_OFFSET ``, sine-index step between phases
- `SHOOT_CYCLES`, 48, width of the `shoot` pulse in clk cycles
- `TX_TIMEOUT`, 4800, max clk cycles allowed for all TX busy to clear

Ports:
- `clk` in 1: 48 MHz HFOSC clock; one clock; reset is synchronous and active-high
- `reset` in 1: synchronous, active-high
- `frame_start` in 1: one-cycle request to run a frame
- `base_index` in 16: sine index of module 0 / phase 0, sampled on accepted `frame_start`
- `sin_addr` out 16: sine RAM address
- `sin_data` in 8: sine RAM data, valid 1 cycle after `sin_addr`
- `data_to_tx` out 8*NUM_MODULES: byte for module i at bits [8i+7:8i]
- `start_tx` out NUM_MODULES: per-UART start strobes
- `tx_busy` in NUM_MODULES: per-UART busy flags
- `shoot` out 1: fire pulse to modules
- `busy` out 1: high whenever the FSM is not in IDLE
- `frame_done` out 1: one-cycle pulse, frame completed
- `tx_timeout` out 1: one-cycle pulse, frame aborted on timeout

## Operation
- States: IDLE, FETCH, LOAD, DISPATCH, WAIT_TX, SHOOT.
- **IDLE**
  - `frame_start`=1 latches `base_index` and clears phase j and module i to 0, then goes to FETCH.
  - `frame_start` in any other state is ignored; it is not queued.
- **FETCH**
  - Drives `sin_addr` = base + i*MODULE_OFFSET + j*PHASE_OFFSET, computed modulo 2^16 (wraps, no saturation).
  - Goes to LOAD.
- **LOAD**
  - Writes `sin_data` into byte i of `data_to_tx`.
  - If i < NUM_MODULES-1: increments i and returns to FETCH.
  - Otherwise: goes to DISPATCH.
- **DISPATCH**
  - Waits until `tx_busy` == 0 on all bits.
  - Then drives `start_tx` all-ones for exactly 1 cycle and goes to WAIT_TX.
- **WAIT_TX**
  - The first 2 cycles are a blanking window while the UART raises busy; `tx_busy` is not evaluated during them.
  - After the window, all-zero `tx_busy`: if j < NUM_PHASES-1, increments j, clears i and goes to FETCH; otherwise goes to SHOOT.
  - The timeout counter runs from entry to WAIT_TX. If it reaches TX_TIMEOUT, the FSM pulses `tx_timeout`, skips `shoot`, and goes to IDLE.
- **SHOOT**
  - `shoot` is high for SHOOT_CYCLES cycles.
  - `frame_done` pulses on the last of those cycles, then the FSM goes to IDLE.
- `data_to_tx` holds its last value between frames.

## Timing
- Reset values: `sin_addr`=0, `data_to_tx`=0, `start_tx`=0, `shoot`=0, `busy`=0, `frame_done`=0, `tx_timeout`=0; state=IDLE.
- Reset mid-frame aborts on the next edge. No `shoot` and no `frame_done` follow the abort.
- Table-load latency per phase: 2*NUM_MODULES cycles (FETCH+LOAD per module), i.e. 18 cycles at 9 modules.
- `start_tx` follows the DISPATCH cycle in which `tx_busy` is seen all-zero by exactly 1 cycle.
- `busy` rises the cycle after `frame_start` is accepted and falls the cycle after `frame_done` or `tx_timeout`.
- Nominal frame length: NUM_PHASES*(2*NUM_MODULES + 1 + 2 + T_uart) + SHOOT_CYCLES, where T_uart is the UART byte time.
- Simultaneous events:
  - `reset` wins over everything.
  - A timeout in the same cycle as `tx_busy` clearing takes the success path.

## Structure
- Shared package `pwm_sched_pkg.vh`:
  - state encodings
  - `NUM_MODULES`/`NUM_PHASES`/offset macros, reused from macros.vh
  - `SHOOT_CYCLES`, `TX_TIMEOUT`
- One natural sub-module: `sin_index_gen`. It holds the i/j counters, the latched base, and the registered modulo-2^16 address adder with `last_module`/`last_phase` flags.
- The FSM, the shoot counter and the timeout counter stay in the top of `pwm_frame_scheduler`.

## Test plan
- **Basic frame:** base=0, RAM returns the low byte of the address, UART model busy for 100 cycles → the following hold:
  - 3 `start_tx` all-ones strobes
  - byte i of phase j = i*MODULE_OFFSET + j*PHASE_OFFSET
  - `shoot` high 48 cycles
  - one `frame_done`
- **Wrap-around:** base=16'hFFF0 → addresses wrap modulo 2^16, with no X and no saturation.
- **Stuck UART:** module 4 `tx_busy` held high after the phase-0 strobe → `tx_timeout` pulses 4800 cycles after WAIT_TX entry, `shoot` never rises, `busy` falls.
- **Request while busy:** `frame_start` re-asserted mid-frame → ignored; exactly one `frame_done`.
- **Reset mid-frame:** `reset` asserted during phase-1 LOAD → next edge has all outputs at reset values, with no `shoot` afterwards.
- **Busy before dispatch:** module 0 busy at DISPATCH entry for 50 cycles → `start_tx` delayed until the cycle after it clears.
